// File: rtl/bcd_seq_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS seven-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on seg_out.
module bcd_seq_display #(
   parameter int unsigned BIN_W          = 20,
   parameter int unsigned DIGITS         = 6,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SEG_W = 7 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [6:0]  SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0]  SEG_DASH  = SEG_ACTIVE_LOW ? 7'h3F : 7'h40;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Active-high gfedcba pattern for one digit, then polarity applied; 10-15 blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] on;
      case (d)
         4'd0:    on = 7'h3F;
         4'd1:    on = 7'h06;
         4'd2:    on = 7'h5B;
         4'd3:    on = 7'h4F;
         4'd4:    on = 7'h66;
         4'd5:    on = 7'h6D;
         4'd6:    on = 7'h7D;
         4'd7:    on = 7'h07;
         4'd8:    on = 7'h7F;
         4'd9:    on = 7'h6F;
         default: on = 7'h00;
      endcase
      return SEG_ACTIVE_LOW ? ~on : on;
   endfunction

   state_t             r_state,     w_state_nxt;
   logic [BIN_W-1:0]   r_bin,       w_bin_nxt;
   logic [BCD_W-1:0]   r_bcd,       w_bcd_nxt;
   logic               r_ovf_w,     w_ovf_w_nxt;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
   logic               r_busy,      w_busy_nxt;
   logic               r_done,      w_done_nxt;
   logic               r_ovf,       w_ovf_nxt;
   logic [BCD_W-1:0]   r_bcd_out,   w_bcd_out_nxt;
   logic [SEG_W-1:0]   r_seg_out,   w_seg_out_nxt;

   logic [BCD_W-1:0]       w_bcd_adj;
   logic [BCD_W+BIN_W:0]   w_shifted;
   logic [SEG_W-1:0]       w_seg_disp;
`ifdef LEADING_ZERO_BLANK_EN
   logic                   w_lead;
`endif

   // Add-3 correction on every digit >= 5, then shift {carry, bcd, bin} left by one.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      w_shifted = {1'b0, w_bcd_adj, r_bin} << 1;
   end

   // Display pattern from the final working digits; overflow dashes win.
   always_comb begin
      w_seg_disp = '0;
`ifdef LEADING_ZERO_BLANK_EN
      w_lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         if ((r_bcd[4*i +: 4] != 4'd0) || (i == 0)) begin
            w_lead = 1'b0;
         end
         w_seg_disp[7*i +: 7] = w_lead ? SEG_BLANK : seg_decode(r_bcd[4*i +: 4]);
      end
`else
      for (int i = 0; i < int'(DIGITS); i++) begin
         w_seg_disp[7*i +: 7] = seg_decode(r_bcd[4*i +: 4]);
      end
`endif
      if (r_ovf_w) begin
         w_seg_disp = {DIGITS{SEG_DASH}};
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_bin_nxt     = r_bin;
      w_bcd_nxt     = r_bcd;
      w_ovf_w_nxt   = r_ovf_w;
      w_cnt_nxt     = r_cnt;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_ovf_nxt     = r_ovf;
      w_bcd_out_nxt = r_bcd_out;
      w_seg_out_nxt = r_seg_out;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_bin_nxt   = bin_in;
               w_bcd_nxt   = '0;
               w_ovf_w_nxt = 1'b0;
               w_cnt_nxt   = CNT_W'(BIN_W);
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {w_bcd_nxt, w_bin_nxt} = w_shifted[BCD_W+BIN_W-1:0];
            w_ovf_w_nxt = r_ovf_w | w_shifted[BCD_W+BIN_W];
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_bcd_out_nxt = r_bcd;
            w_seg_out_nxt = w_seg_disp;
            w_ovf_nxt     = r_ovf_w;
            w_done_nxt    = 1'b1;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_ovf_w   <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_bcd_out <= '0;
         r_seg_out <= {DIGITS{SEG_BLANK}};
      end else begin
         r_state   <= w_state_nxt;
         r_bin     <= w_bin_nxt;
         r_bcd     <= w_bcd_nxt;
         r_ovf_w   <= w_ovf_w_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_ovf     <= w_ovf_nxt;
         r_bcd_out <= w_bcd_out_nxt;
         r_seg_out <= w_seg_out_nxt;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign bcd_out  = r_bcd_out;
   assign seg_out  = r_seg_out;

endmodule

// File: tb/tb_bcd_seq_display.sv
// Randomized self-checking bench for bcd_seq_display against an arithmetic decimal model.
module tb_bcd_seq_display;

   localparam int unsigned BIN_W  = 20;
   localparam int unsigned DIGITS = 6;
   localparam int unsigned LIMIT  = 1000000;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif
   localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [BIN_W-1:0]  bin_in;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [23:0]       bcd_out;
   logic [41:0]       seg_out;

   int n_checks = 0;
   int n_fails  = 0;

   bcd_seq_display #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .bcd_out  (bcd_out),
      .seg_out  (seg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] m_bcd(input int unsigned v);
      int unsigned r = v % LIMIT;
      logic [23:0] b = '0;
      for (int i = 0; i < 6; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic logic [41:0] m_seg(input int unsigned v);
      int unsigned r = v;
      int          d [6];
      int          top = 0;
      logic [41:0] s = '0;
      if (v >= LIMIT) return {6{7'h3F}};
      for (int i = 0; i < 6; i++) begin
         d[i] = int'(r % 10);
         r = r / 10;
         if (d[i] != 0) top = i;
      end
      for (int i = 0; i < 6; i++) begin
         s[7*i +: 7] = (LZB && i > top) ? 7'h7F : SEG_TBL[d[i]];
      end
      return s;
   endfunction

   task automatic check_results(input int unsigned v);
      check("bcd_out", 64'(bcd_out), 64'(m_bcd(v)));
      check("overflow", 64'(overflow), 64'(v >= LIMIT));
      check("seg_out", 64'(seg_out), 64'(m_seg(v)));
   endtask

   // One conversion with latency, busy, done-width and result checks.
   task automatic run_conv(input int unsigned v);
      int n = 0;
      bit seen = 1'b0;
      start  = 1'b1;
      bin_in = BIN_W'(v);
      @(posedge clk); #1;
      start  = 1'b0;
      bin_in = BIN_W'($urandom);
      check("busy_rise", 64'(busy), 64'd1);
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      check("latency", 64'(n), 64'd21);
      check("busy_at_done", 64'(busy), 64'd0);
      check_results(v);
      @(posedge clk); #1;
      check("done_width", 64'(done), 64'd0);
   endtask

   initial begin
      int unsigned v;
      int n;
      int dones;
      logic [23:0] first_bcd;

      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_bcd", 64'(bcd_out), 64'd0);
      check("rst_seg", 64'(seg_out), 64'({6{7'h7F}}));

      run_conv(0);
      run_conv(123456);
      check("d0_six", 64'(seg_out[6:0]), 64'h02);
      check("d5_one", 64'(seg_out[41:35]), 64'h79);
      run_conv(999999);
      run_conv(1048575);
      run_conv(42);
      run_conv(1000000);
      run_conv(7);

      for (int k = 0; k < 16; k++) begin
         v = (k % 4 == 0) ? $urandom_range(1048575, 1000000) : $urandom_range(999999, 0);
         run_conv(v);
      end

      // Start pulsed mid-conversion must be ignored.
      v = 314159;
      start = 1'b1; bin_in = BIN_W'(v);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; bin_in = BIN_W'(271828);
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0; first_bcd = '0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (dones == 0) first_bcd = bcd_out;
            dones++;
         end
      end
      check("ign_done_cnt", 64'(dones), 64'd1);
      check("ign_bcd", 64'(first_bcd), 64'(m_bcd(v)));

      // Back-to-back with start held high.
      start = 1'b1; bin_in = BIN_W'(55555);
      @(posedge clk); #1;
      bin_in = BIN_W'(1234567 % 1048576);
      n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      check("b2b_lat1", 64'(n), 64'd21);
      check("b2b_bcd1", 64'(bcd_out), 64'(m_bcd(55555)));
      n = 0;
      @(posedge clk); #1; n++;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      start = 1'b0;
      check("b2b_period", 64'(n), 64'd22);
      check("b2b_bcd2", 64'(bcd_out), 64'(m_bcd(1234567 % 1048576)));
      repeat (3) @(posedge clk);
      #1;

      // Reset 10 cycles into a conversion aborts it.
      start = 1'b1; bin_in = BIN_W'(888888);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);
      check("mid_rst_bcd", 64'(bcd_out), 64'd0);
      check("mid_rst_seg", 64'(seg_out), 64'({6{7'h7F}}));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("mid_rst_no_done", 64'(dones), 64'd0);
      run_conv(654321);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
